mux_pry: RTL and testbench

MUX_PRY -- requirements
Module: mux_pry

---
 rtl/mux_pry_pkg.sv | 37 +++
 rtl/mux_pry_grp.sv | 32 +++
 rtl/mux_pry.sv | 123 ++++++++++++
 tb/tb_mux_pry.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mux_pry_pkg.sv
// ---------------------------------------------------------------------------
// mux_pry_pkg
// Elaboration-time helpers for the priority multiplexer tree. Only constant
// functions live here; every parameter stays local to the modules.
//   cdiv        : ceiling division, used for group counts per tree level
//   level_width : number of (vld, dat) pairs entering a given tree level
//   tree_levels : number of group levels needed to reduce WIDTH to one result
// ---------------------------------------------------------------------------
package mux_pry_pkg;

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int level_width(input int width, input int split, input int lvl);
        int n;
        n = width;
        for (int i = 0; i < lvl; i++) begin
            n = cdiv(n, split);
        end
        return n;
    endfunction

    // Always at least one level, so WIDTH=1 still goes through one group.
    function automatic int tree_levels(input int width, input int split);
        int n;
        int l;
        n = cdiv(width, split);
        l = 1;
        while (n > 1) begin
            n = cdiv(n, split);
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/mux_pry_grp.sv
// ---------------------------------------------------------------------------
// mux_pry_grp
// One N-input priority group: the highest set pry bit selects its ary entry.
// dat is all zeros when no pry bit is set, so that group results from the
// next tree level can be treated as plain (vld, dat) inputs again.
// Ports:
//   pry [N-1:0] : request bits, higher index wins
//   ary [N]     : data entries
//   vld         : OR of pry
//   dat         : selected entry, or zero when vld is low
// ---------------------------------------------------------------------------
module mux_pry_grp #(
    parameter type DAT_T = logic [7:0],
    parameter int  N     = 3
) (
    input  logic [N-1:0] pry,
    input  DAT_T         ary [N],
    output logic         vld,
    output DAT_T         dat
);

    always_comb begin
        vld = |pry;
        dat = '0;
        for (int i = 0; i < N; i++) begin
            if (pry[i]) begin
                dat = ary[i];
            end
        end
    end

endmodule

// File: rtl/mux_pry.sv
// ---------------------------------------------------------------------------
// mux_pry
// Priority multiplexer: dat = ary[k] for the highest k with pry[k] set,
// vld = |pry, and dat = 0 when nothing is requested.
// IMPLEMENTATION selects a flat loop (0) or a SPLIT-ary tree of
// mux_pry_grp instances (1); both produce identical results.
// REGISTERED=1 adds one output register stage with asynchronous reset.
// Ports:
//   clk             : clock, only used when REGISTERED=1
//   rst             : asynchronous active-high reset, only used when REGISTERED=1
//   pry [WIDTH-1:0] : request bits, bit i requests ary[i]
//   ary [WIDTH-1:0] : data inputs
//   vld             : at least one request is set
//   dat             : data of the highest-index request
// ---------------------------------------------------------------------------
module mux_pry
    import mux_pry_pkg::*;
#(
    parameter type DAT_T          = logic [7:0],
    parameter int  WIDTH          = 9,
    parameter int  SPLIT          = 3,
    parameter int  IMPLEMENTATION = 0,
    parameter int  REGISTERED     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pry,
    input  DAT_T             ary [WIDTH-1:0],
    output logic             vld,
    output DAT_T             dat
);

    logic comb_vld;
    DAT_T comb_dat;

    genvar gi, gj, gk;

    generate
        if (IMPLEMENTATION == 0) begin : g_flat
            // Later (higher-index) hits overwrite earlier ones.
            always_comb begin
                comb_vld = |pry;
                comb_dat = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (pry[i]) begin
                        comb_dat = ary[i];
                    end
                end
            end
        end else begin : g_tree
            localparam int LEVELS = tree_levels(WIDTH, SPLIT);

            // Row l holds the (vld, dat) pairs entering level l; row LEVELS
            // holds the single final result in entry 0. Entries beyond the
            // live width of a row are tied to zero.
            logic lvl_vld [LEVELS+1][WIDTH];
            DAT_T lvl_dat [LEVELS+1][WIDTH];

            for (gi = 0; gi < WIDTH; gi++) begin : g_in
                assign lvl_vld[0][gi] = pry[gi];
                assign lvl_dat[0][gi] = ary[gi];
            end

            for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
                localparam int N_IN  = level_width(WIDTH, SPLIT, gi);
                localparam int N_OUT = cdiv(N_IN, SPLIT);

                for (gj = 0; gj < N_OUT; gj++) begin : g_grp
                    localparam int BASE = gj * SPLIT;
                    // The last group of a level may be short.
                    localparam int LEN  = (N_IN - BASE < SPLIT) ? (N_IN - BASE) : SPLIT;

                    logic [LEN-1:0] grp_pry;
                    DAT_T           grp_ary [LEN];

                    for (gk = 0; gk < LEN; gk++) begin : g_slice
                        assign grp_pry[gk] = lvl_vld[gi][BASE+gk];
                        assign grp_ary[gk] = lvl_dat[gi][BASE+gk];
                    end

                    mux_pry_grp #(
                        .DAT_T (DAT_T),
                        .N     (LEN)
                    ) u_grp (
                        .pry (grp_pry),
                        .ary (grp_ary),
                        .vld (lvl_vld[gi+1][gj]),
                        .dat (lvl_dat[gi+1][gj])
                    );
                end

                for (gj = N_OUT; gj < WIDTH; gj++) begin : g_pad
                    assign lvl_vld[gi+1][gj] = 1'b0;
                    assign lvl_dat[gi+1][gj] = '0;
                end
            end

            assign comb_vld = lvl_vld[LEVELS][0];
            assign comb_dat = lvl_dat[LEVELS][0];
        end
    endgenerate

    generate
        if (REGISTERED != 0) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= 1'b0;
                    dat <= '0;
                end else begin
                    vld <= comb_vld;
                    dat <= comb_dat;
                end
            end
        end else begin : g_comb
            // clk and rst are intentionally ignored in the combinational build.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign vld = comb_vld;
            assign dat = comb_dat;
        end
    endgenerate

endmodule

// File: tb/tb_mux_pry.sv
// ---------------------------------------------------------------------------
// tb_mux_pry
// Drives four mux_pry builds (flat/tree x combinational/registered) with
// WIDTH=9, SPLIT=3 and ary[i]=i. Combinational builds are checked against a
// table of hand-computed vectors and against a behavioural model on random
// requests; the registered builds go through latency and reset sequences.
// ---------------------------------------------------------------------------
module tb_mux_pry;

    localparam int W = 9;

    logic         clk;
    logic         rst;
    logic [W-1:0] pry;
    logic [7:0]   ary [W-1:0];

    logic       c0_vld, c1_vld, r0_vld, r1_vld;
    logic [7:0] c0_dat, c1_dat, r0_dat, r1_dat;

    int n_checks = 0;
    int n_fail   = 0;

    mux_pry #(.WIDTH(W), .SPLIT(3), .IMPLEMENTATION(0), .REGISTERED(0)) u_c0 (
        .clk(clk), .rst(rst), .pry(pry), .ary(ary), .vld(c0_vld), .dat(c0_dat));
    mux_pry #(.WIDTH(W), .SPLIT(3), .IMPLEMENTATION(1), .REGISTERED(0)) u_c1 (
        .clk(clk), .rst(rst), .pry(pry), .ary(ary), .vld(c1_vld), .dat(c1_dat));
    mux_pry #(.WIDTH(W), .SPLIT(3), .IMPLEMENTATION(0), .REGISTERED(1)) u_r0 (
        .clk(clk), .rst(rst), .pry(pry), .ary(ary), .vld(r0_vld), .dat(r0_dat));
    mux_pry #(.WIDTH(W), .SPLIT(3), .IMPLEMENTATION(1), .REGISTERED(1)) u_r1 (
        .clk(clk), .rst(rst), .pry(pry), .ary(ary), .vld(r1_vld), .dat(r1_dat));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] pry;
        logic         vld;
        logic [7:0]   dat;
    } vec_t;

    vec_t vecs [15];

    // Behavioural model: scan from the top index down, first hit wins.
    function automatic logic [8:0] model(input logic [W-1:0] p);
        for (int i = W - 1; i >= 0; i--) begin
            if (p[i]) return {1'b1, 8'(i)};
        end
        return 9'd0;
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got vld=%b dat=%0d, expected vld=%b dat=%0d",
                     name, act[8], act[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic check_reg(input string name, input logic ev, input logic [7:0] ed);
        check({name, " r0"}, {r0_vld, r0_dat}, {ev, ed});
        check({name, " r1"}, {r1_vld, r1_dat}, {ev, ed});
        $display("reg  %-14s pry=%b r0=%b/%0d r1=%b/%0d", name, pry, r0_vld, r0_dat, r1_vld, r1_dat);
    endtask

    initial begin
        logic [8:0] exp;

        for (int i = 0; i < W; i++) ary[i] = 8'(i);
        rst = 1'b0;
        pry = '0;

        vecs[0] = '{9'b000000000, 1'b0, 8'd0};
        for (int i = 0; i < W; i++) vecs[1+i] = '{9'(1 << i), 1'b1, 8'(i)};
        vecs[10] = '{9'b000010110, 1'b1, 8'd4};
        vecs[11] = '{9'b111111111, 1'b1, 8'd8};
        vecs[12] = '{9'b000000011, 1'b1, 8'd1};
        vecs[13] = '{9'b000001000, 1'b1, 8'd3};
        vecs[14] = '{9'b100000001, 1'b1, 8'd8};

        // Reset state of the registered builds.
        #1 rst = 1'b1;
        #2;
        check_reg("reset", 1'b0, 8'd0);

        // Directed table against both combinational builds.
        for (int v = 0; v < 15; v++) begin
            @(negedge clk);
            pry = vecs[v].pry;
            #1;
            check($sformatf("vec%0d c0", v), {c0_vld, c0_dat}, {vecs[v].vld, vecs[v].dat});
            check($sformatf("vec%0d c1", v), {c1_vld, c1_dat}, {vecs[v].vld, vecs[v].dat});
            $display("vec  %0d pry=%b c0=%b/%0d c1=%b/%0d", v, pry, c0_vld, c0_dat, c1_vld, c1_dat);
        end

        // Random requests against the model.
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            pry = 9'($urandom_range(0, 511));
            #1;
            exp = model(pry);
            check($sformatf("rnd%0d c0", r), {c0_vld, c0_dat}, exp);
            check($sformatf("rnd%0d c1", r), {c1_vld, c1_dat}, exp);
            $display("rnd  %0d pry=%b c0=%b/%0d c1=%b/%0d", r, pry, c0_vld, c0_dat, c1_vld, c1_dat);
        end

        // Registered: one cycle latency.
        @(negedge clk);
        pry = '0;
        rst = 1'b0;
        @(negedge clk);
        pry = 9'(1 << 5);
        #1;
        check_reg("pre-edge", 1'b0, 8'd0);
        @(posedge clk);
        #1;
        check_reg("post-edge", 1'b1, 8'd5);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check_reg("async-rst", 1'b0, 8'd0);
        #1 rst = 1'b0;
        #0.5;
        check_reg("rst-released", 1'b0, 8'd0);
        @(posedge clk);
        #1;
        check_reg("first-load", 1'b1, 8'd5);

        // Registered output holds until the next edge.
        @(negedge clk);
        pry = 9'b000010110;
        #1;
        check_reg("hold", 1'b1, 8'd5);
        @(posedge clk);
        #1;
        check_reg("update", 1'b1, 8'd4);
        @(negedge clk);
        pry = '0;
        @(posedge clk);
        #1;
        check_reg("idle", 1'b0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
